// File: rtl/data_memory_subword_if.sv
// Request/response bus of the sub-word data memory.
// master drives the request side and slave drives completion and status.
interface data_memory_subword_if #(
  parameter int ADDR_W = 12
);
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              ready;
  logic              busy;
  logic              error;

  modport master (
    output memRead, memWrite, address, size, sign_ext, data_in,
    input  data_out, ready, busy, error
  );

  modport slave (
    input  memRead, memWrite, address, size, sign_ext, data_in,
    output data_out, ready, busy, error
  );
endinterface

// File: rtl/data_memory_subword.sv
// Word-organised data memory with byte/halfword/word access. LATENCY+1 cycles to ready,
// one request per LATENCY+2 cycles; requests seen while busy are dropped, never queued.
module data_memory_subword #(
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 1,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_subword_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dout_q;
  logic              ready_q;
  logic              error_q;
  logic              busy_q;
  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              access;
  logic              legal;
  logic [31:0]       word_rd;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rdata_d;
  logic [31:0]       wsrc;
  logic [3:0]        lane_en;
  logic [31:0]       wword_d;

  assign idx     = addr_q[ADDR_W-1:2];
  assign lane    = addr_q[1:0];
  assign access  = (state_q == S_WAIT) && (cnt_q == 2'd0);
  assign word_rd = mem_q[idx];
  assign rd_byte = 8'(word_rd >> {lane, 3'b000});
  assign rd_half = 16'(word_rd >> {lane[1], 4'b0000});

  always_comb begin
    legal = 1'b1;
    case (size_q)
      2'b01:   legal = ~lane[0];
      2'b10:   legal = (lane == 2'b00);
      2'b11:   legal = 1'b0;
      default: legal = 1'b1;
    endcase
  end

  always_comb begin
    rdata_d = word_rd;
    case (size_q)
      2'b00:   rdata_d = {{24{sext_q & rd_byte[7]}}, rd_byte};
      2'b01:   rdata_d = {{16{sext_q & rd_half[15]}}, rd_half};
      default: rdata_d = word_rd;
    endcase
  end

  // Sub-word data is replicated across lanes so each lane picks its own slice.
  always_comb begin
    wsrc    = wdata_q;
    lane_en = 4'b1111;
    case (size_q)
      2'b00: begin
        wsrc    = {4{wdata_q[7:0]}};
        lane_en = 4'b0001 << lane;
      end
      2'b01: begin
        wsrc    = {2{wdata_q[15:0]}};
        lane_en = 4'b0011 << {lane[1], 1'b0};
      end
      default: begin
        wsrc    = wdata_q;
        lane_en = 4'b1111;
      end
    endcase
  end

  always_comb begin
    wword_d = word_rd;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        wword_d[8*i +: 8] = wsrc[8*i +: 8];
      end
    end
  end

  generate
    if (INIT_ZERO) begin : g_mem_clr
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
          end
        end else if (access && op_wr_q && legal) begin
          mem_q[idx] <= wword_d;
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (access && op_wr_q && legal) begin
          mem_q[idx] <= wword_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.memRead || bus.memWrite) begin
            op_wr_q <= bus.memWrite;
            addr_q  <= bus.address;
            size_q  <= bus.size;
            sext_q  <= bus.sign_ext;
            wdata_q <= bus.data_in;
            cnt_q   <= 2'(LATENCY - 1);
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            ready_q <= 1'b1;
            error_q <= ~legal;
            if (!op_wr_q && legal) begin
              dout_q <= rdata_d;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out = dout_q;
  assign bus.ready    = ready_q;
  assign bus.error    = error_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/data_memory_subword.md
DATA_MEMORY_SUBWORD -- requirements
Module: data_memory_subword

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width; storage depth SHALL be 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter LATENCY, default 1, access latency in cycles; legal range 1..4.
REQ-003 Parameter INIT_ZERO, default 1, when 1 reset clears every storage word to 0.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 memRead  input  1  read request, sampled only in IDLE.
REQ-007 memWrite  input  1  write request, sampled only in IDLE; wins over memRead when both high.
REQ-008 address  input  ADDR_W  byte address.
REQ-009 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 sign_ext  input  1  1 sign-extends byte/halfword reads, 0 zero-extends.
REQ-011 data_in  input  32  write data; byte/halfword taken from low bits.
REQ-012 data_out  output  32  read result; holds last read result until next read completes.
REQ-013 ready  output  1  one-cycle pulse marking completion of an accepted request.
REQ-014 busy  output  1  high while a request is in flight (not IDLE).
REQ-015 error  output  1  one-cycle pulse, with ready, for misaligned or illegal-size request.

Function
REQ-016 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-017 IDLE: memRead|memWrite at edge k SHALL latch address, size, sign_ext, data_in, op; load counter with LATENCY-1; go WAIT.
REQ-018 WAIT: counter decrements each edge; at counter 0 the access SHALL be performed at that edge and state goes DONE.
REQ-019 DONE: ready=1 for exactly one cycle; next edge returns to IDLE; new requests accepted only from IDLE.
REQ-020 ready SHALL first be high in the cycle after edge k+LATENCY; request-to-request throughput is one per LATENCY+2 cycles.
REQ-021 Requests presented while busy=1 SHALL be ignored, not queued.
REQ-022 Word index = address[ADDR_W-1:2]; byte lane = address[1:0].
REQ-023 Byte write SHALL update only lane address[1:0]; halfword write only lanes {address[1],0} and {address[1],1}; word write all four; little-endian (lane 0 = bits 7:0).
REQ-024 Byte/halfword read SHALL place selected lanes in low bits, upper bits filled by sign_ext rule.
REQ-025 Misaligned (halfword with address[0]=1, word with address[1:0]!=0) or size=11: no storage change, data_out unchanged, error and ready pulse together at normal completion time.
REQ-026 memRead and memWrite both high: treated as write only; data_out unchanged.
REQ-027 Write completion SHALL leave data_out unchanged.
REQ-028 Read of a word in the same access as no pending write returns stored contents; a read accepted after a write's ready pulse SHALL observe the written data.

Reset
REQ-029 reset asserted SHALL immediately force IDLE, busy=0, ready=0, error=0, data_out=0, counter=0, independent of clk.
REQ-030 INIT_ZERO=1: all words SHALL read 0 after reset; INIT_ZERO=0: storage untouched.
REQ-031 Reset during WAIT SHALL abort the access: no storage write, no ready pulse.
REQ-032 First request accepted on the first rising edge with reset low.

Verification
REQ-033 LATENCY=1: word write 0x000002EC to address 0x024, then word read 0x024 -> ready one cycle after edge k+1, data_out=0x000002EC.
REQ-034 Word 0x00000000 preset; byte write 0x80 to 0x001, read byte 0x001 sign_ext=1 -> 0xFFFFFF80; sign_ext=0 -> 0x00000080; word read 0x000 -> 0x00008000.
REQ-035 Halfword read at 0x003 -> error=1 with ready, data_out keeps prior value; size=11 at 0x000 -> error=1, storage unchanged.
REQ-036 LATENCY=3: read request held high through busy -> exactly one ready per accepted request, spaced 5 cycles; request raised during busy ignored.
REQ-037 Word write 0xDEADBEEF to 0x010 with reset pulsed during WAIT -> no ready; subsequent read 0x010 returns 0x00000000 (INIT_ZERO=1).
REQ-038 memRead=memWrite=1, data_in 0x12345678, address 0x008 -> data_out unchanged, following read returns 0x12345678.
